// File: rtl/tb_sim_ctrl.sv
// Simulation controller: staggered reset release, run-cycle counting,
// tohost pass/fail/timeout verdict. Optional console: TB_SIM_CTRL_CONSOLE_EN.
module tb_sim_ctrl #(
    parameter int                 NUM_RST         = 2,
    parameter int                 RST_HOLD_CYCLES = 2,
    parameter int                 RST_STAGGER     = 4,
    parameter int                 ADDR_W          = 32,
    parameter int                 DATA_W          = 32,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR     = 32'h8000_1000,
    parameter int                 CNT_W           = 32,
    parameter int                 TIMEOUT_CYCLES  = 2500
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                mon_valid_i,
    input  logic                mon_we_i,
    input  logic [ADDR_W-1:0]   mon_addr_i,
    input  logic [DATA_W-1:0]   mon_wdata_i,
    output logic [NUM_RST-1:0]  rstn_o,
    output logic                running_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                timeout_o,
    output logic [DATA_W-2:0]   fail_code_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic                console_valid_o,
    output logic [7:0]          console_char_o
);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STAGGER = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    // Value of the sequencing counter on the edge releasing the last domain.
    localparam logic [31:0] LAST_REL =
        32'(RST_HOLD_CYCLES + (NUM_RST - 1) * RST_STAGGER - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [31:0]        seq_q, seq_d;
    logic [NUM_RST-1:0] rstn_q, rstn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               to_q, to_d;
    logic [DATA_W-2:0]  fc_q, fc_d;

    logic               wr;
    logic               hit;
    logic               to_hit;

    assign wr     = mon_valid_i && mon_we_i;
    assign hit    = wr && (mon_addr_i == TOHOST_ADDR) && mon_wdata_i[0];
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Next-state: reset release schedule, run counter and verdict capture.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        rstn_d  = rstn_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        to_d    = to_q;
        fc_d    = fc_q;
        unique case (state_q)
            S_HOLD, S_STAGGER: begin
                seq_d = seq_q + 32'd1;
                for (int i = 0; i < NUM_RST; i++) begin
                    if (seq_q == 32'(RST_HOLD_CYCLES + i * RST_STAGGER - 1))
                        rstn_d[i] = 1'b1;
                end
                if (seq_q == LAST_REL)
                    state_d = S_RUN;
                else if (seq_q == 32'(RST_HOLD_CYCLES - 1))
                    state_d = S_STAGGER;
            end
            S_RUN: begin
                if (hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (mon_wdata_i == DATA_W'(1));
                    fc_d    = (mon_wdata_i == DATA_W'(1)) ? '0
                              : mon_wdata_i[DATA_W-1:1];
                end else if (to_hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_HOLD;
        endcase
    end

    // State and verdict registers; everything clears on board reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_HOLD;
            seq_q   <= '0;
            rstn_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            rstn_q  <= rstn_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
            fc_q    <= fc_d;
        end
    end

    assign rstn_o      = rstn_q;
    assign running_o   = (state_q == S_RUN);
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = to_q;
    assign fail_code_o = fc_q;
    assign cycle_cnt_o = cnt_q;

`ifdef TB_SIM_CTRL_CONSOLE_EN
    localparam logic [ADDR_W-1:0] CON_ADDR = TOHOST_ADDR + ADDR_W'(4);

    logic       con_v_q, con_v_d;
    logic [7:0] con_c_q, con_c_d;

    // Console strobe: one pulse per console write seen in RUN.
    always_comb begin
        con_v_d = (state_q == S_RUN) && wr && (mon_addr_i == CON_ADDR);
        con_c_d = con_v_d ? mon_wdata_i[7:0] : con_c_q;
    end

    // Console byte register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            con_v_q <= 1'b0;
            con_c_q <= '0;
        end else begin
            con_v_q <= con_v_d;
            con_c_q <= con_c_d;
        end
    end

    assign console_valid_o = con_v_q;
    assign console_char_o  = con_v_q ? con_c_q : 8'h00;
`else
    assign console_valid_o = 1'b0;
    assign console_char_o  = 8'h00;
`endif

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Directed bench for tb_sim_ctrl: reset sequencing, pass, fail,
// filtering, timeout, async reset and console output.
module tb_tb_sim_ctrl;

    logic        clk = 1'b0;
    logic        rstn_a = 1'b0;
    logic        rstn_t = 1'b0;
    logic        rstn_b = 1'b0;
    logic        mv = 1'b0;
    logic        mw = 1'b0;
    logic [31:0] ma = '0;
    logic [31:0] md = '0;

    logic [1:0]  a_rstn, t_rstn;
    logic [0:0]  b_rstn;
    logic        a_run, a_done, a_pass, a_to, a_cv;
    logic        t_run, t_done, t_pass, t_to, t_cv;
    logic        b_run, b_done, b_pass, b_to, b_cv;
    logic [30:0] a_fc, t_fc, b_fc;
    logic [31:0] a_cnt, t_cnt, b_cnt;
    logic [7:0]  a_cc, t_cc, b_cc;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tb_sim_ctrl u_a (
        .clk_i(clk), .rstn_i(rstn_a),
        .mon_valid_i(mv), .mon_we_i(mw),
        .mon_addr_i(ma), .mon_wdata_i(md),
        .rstn_o(a_rstn), .running_o(a_run), .done_o(a_done),
        .pass_o(a_pass), .timeout_o(a_to), .fail_code_o(a_fc),
        .cycle_cnt_o(a_cnt), .console_valid_o(a_cv),
        .console_char_o(a_cc)
    );

    tb_sim_ctrl #(.TIMEOUT_CYCLES(10)) u_t (
        .clk_i(clk), .rstn_i(rstn_t),
        .mon_valid_i(mv), .mon_we_i(mw),
        .mon_addr_i(ma), .mon_wdata_i(md),
        .rstn_o(t_rstn), .running_o(t_run), .done_o(t_done),
        .pass_o(t_pass), .timeout_o(t_to), .fail_code_o(t_fc),
        .cycle_cnt_o(t_cnt), .console_valid_o(t_cv),
        .console_char_o(t_cc)
    );

    tb_sim_ctrl #(.NUM_RST(1), .RST_HOLD_CYCLES(3)) u_b (
        .clk_i(clk), .rstn_i(rstn_b),
        .mon_valid_i(mv), .mon_we_i(mw),
        .mon_addr_i(ma), .mon_wdata_i(md),
        .rstn_o(b_rstn), .running_o(b_run), .done_o(b_done),
        .pass_o(b_pass), .timeout_o(b_to), .fail_code_o(b_fc),
        .cycle_cnt_o(b_cnt), .console_valid_o(b_cv),
        .console_char_o(b_cc)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mv = 1'b1; mw = 1'b1; ma = a; md = d;
    endtask

    task automatic idle();
        mv = 1'b0; mw = 1'b0; ma = '0; md = '0;
    endtask

    // Check u_a: rstn, running, done, pass, timeout, fail code, count.
    task automatic chk_a(input string tag, input logic [1:0] r,
                         input logic ru, input logic dn, input logic ps,
                         input logic to, input logic [30:0] fc,
                         input logic [31:0] cnt);
        chk({tag, ".rstn"}, 64'(a_rstn), 64'(r));
        chk({tag, ".run"},  64'(a_run),  64'(ru));
        chk({tag, ".done"}, 64'(a_done), 64'(dn));
        chk({tag, ".pass"}, 64'(a_pass), 64'(ps));
        chk({tag, ".to"},   64'(a_to),   64'(to));
        chk({tag, ".fc"},   64'(a_fc),   64'(fc));
        chk({tag, ".cnt"},  64'(a_cnt),  64'(cnt));
    endtask

    // Release u_a from reset and check the release schedule.
    task automatic seq_a(input string tag);
        rstn_a = 1'b1;
        step(1);
        chk_a({tag, ".e1"}, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1);
        chk_a({tag, ".e2"}, 2'b01, 0, 0, 0, 0, 0, 0);
        step(3);
        chk_a({tag, ".e5"}, 2'b01, 0, 0, 0, 0, 0, 0);
        step(1);
        chk_a({tag, ".e6"}, 2'b11, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        step(2);
        chk_a("rst", 2'b00, 0, 0, 0, 0, 0, 0);
        chk("rst.cv", 64'(a_cv), 64'(0));

        // Scenario 1 + 2: sequencing then pass at cnt 100
        seq_a("s1");
        step(100);
        chk_a("s2.c100", 2'b11, 1, 0, 0, 0, 0, 100);
        wr(32'h8000_1000, 32'h1);
        step(1);
        idle();
        chk_a("s2.pass", 2'b11, 0, 1, 1, 0, 0, 100);
        wr(32'h8000_1000, 32'h7);
        step(1);
        idle();
        step(2);
        chk_a("s2.frozen", 2'b11, 0, 1, 1, 0, 0, 100);

        // Scenario 3: filtering then fail code
        rstn_a = 1'b0;
        #1;
        chk_a("s3.rst", 2'b00, 0, 0, 0, 0, 0, 0);
        step(1);
        seq_a("s3");
        wr(32'h8000_1000, 32'h6);
        step(1);
        wr(32'h8000_1008, 32'h7);
        step(1);
        wr(32'h8000_1000, 32'h7);
        mw = 1'b0;
        step(1);
        idle();
        chk_a("s3.filt", 2'b11, 1, 0, 0, 0, 0, 3);
        wr(32'h8000_1000, 32'h7);
        step(1);
        idle();
        chk_a("s3.fail", 2'b11, 0, 1, 0, 0, 3, 3);

        // Scenario 5: async reset at cnt 50, then identical sequence
        rstn_a = 1'b0;
        step(1);
        seq_a("s5a");
        step(50);
        chk_a("s5.c50", 2'b11, 1, 0, 0, 0, 0, 50);
        #2;
        rstn_a = 1'b0;
        #1;
        chk_a("s5.async", 2'b00, 0, 0, 0, 0, 0, 0);
        step(2);
        chk_a("s5.held", 2'b00, 0, 0, 0, 0, 0, 0);
        seq_a("s5b");

        // Scenario 6: console writes on consecutive cycles
        wr(32'h8000_1004, 32'h48);
        step(1);
        wr(32'h8000_1004, 32'h69);
`ifdef TB_SIM_CTRL_CONSOLE_EN
        if (a_cv) $write("%c", a_cc);
        chk("s6.v0", 64'(a_cv), 64'(1));
        chk("s6.c0", 64'(a_cc), 64'h48);
        step(1);
        idle();
        if (a_cv) $write("%c\n", a_cc);
        chk("s6.v1", 64'(a_cv), 64'(1));
        chk("s6.c1", 64'(a_cc), 64'h69);
`else
        chk("s6.v0", 64'(a_cv), 64'(0));
        step(1);
        idle();
        chk("s6.v1", 64'(a_cv), 64'(0));
        chk("s6.c1", 64'(a_cc), 64'(0));
`endif
        step(1);
        chk("s6.v2", 64'(a_cv), 64'(0));
        chk_a("s6.run", 2'b11, 1, 0, 0, 0, 0, 3);
        rstn_a = 1'b0;

        // Scenario 4: timeout at cnt 9
        rstn_t = 1'b1;
        step(6);
        chk("s4.run", 64'(t_run), 64'(1));
        chk("s4.rstn", 64'(t_rstn), 64'(3));
        step(9);
        chk("s4.c9", 64'(t_cnt), 64'(9));
        chk("s4.nd", 64'(t_done), 64'(0));
        step(1);
        chk("s4.done", 64'(t_done), 64'(1));
        chk("s4.to", 64'(t_to), 64'(1));
        chk("s4.pass", 64'(t_pass), 64'(0));
        chk("s4.fc", 64'(t_fc), 64'(0));
        chk("s4.cnt", 64'(t_cnt), 64'(9));
        step(3);
        chk("s4.frz", 64'(t_cnt), 64'(9));

        // Scenario 4b: hit on the timeout cycle wins
        rstn_t = 1'b0;
        step(1);
        rstn_t = 1'b1;
        step(15);
        chk("s4b.c9", 64'(t_cnt), 64'(9));
        wr(32'h8000_1000, 32'h1);
        step(1);
        idle();
        chk("s4b.done", 64'(t_done), 64'(1));
        chk("s4b.pass", 64'(t_pass), 64'(1));
        chk("s4b.to", 64'(t_to), 64'(0));
        chk("s4b.cnt", 64'(t_cnt), 64'(9));

        // Scenario 5b: single domain, hold 3
        rstn_b = 1'b1;
        step(2);
        chk("s5b.e2r", 64'(b_rstn), 64'(0));
        chk("s5b.e2run", 64'(b_run), 64'(0));
        step(1);
        chk("s5b.e3r", 64'(b_rstn), 64'(1));
        chk("s5b.e3run", 64'(b_run), 64'(1));
        chk("s5b.e3cnt", 64'(b_cnt), 64'(0));
        step(1);
        chk("s5b.e4cnt", 64'(b_cnt), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
